udp_line_scheduler: RTL and testbench

- Sequences per-row UDP transmission of the dual-camera line buffer.
- On each frame start it walks rows 0..V_ACT-1 and sends cam0 then cam1 for each row.
- For each packet it raises one trigger to both the line buffer and the UDP packet engine, waits for completion, then enforces an inter-packet gap.
- Sits in the rgmii_clk domain between the frame-start source, line_swap_buffer and udp_packet, and replaces the free-running send trigger.

---
 rtl/udp_line_scheduler.sv | 140 ++++++++++++++
 tb/tb_udp_line_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_line_scheduler.sv
// Purpose : walks rows 0..V_ACT-1 per frame, issuing one cam0 then one cam1 packet per row.
// Latency : frame_start -> trig in 2 cycles; packet period = 1 + tx_done delay + GAP_TICKS + 1.
// Backpr. : holds in WAIT_LINE while !line_ready or tx_busy; WAIT_DONE bounded by TIMEOUT.
// Ports   : clk/rst (sync, active-high); en, frame_start, line_ready, tx_busy, tx_done in;
//           trig, cam_id, row, frame_done, timeout_err, frame_overrun, sent_cnt out (all registered).
module udp_line_scheduler #(
  parameter int V_ACT     = 720,
  parameter int ROW_W     = 10,
  parameter int GAP_TICKS = 125_000,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frame_start,
  input  logic             line_ready,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic             trig,
  output logic             cam_id,
  output logic [ROW_W-1:0] row,
  output logic             frame_done,
  output logic             timeout_err,
  output logic             frame_overrun,
  output logic [15:0]      sent_cnt
);

  // Gap counter spans 0..GAP_TICKS-1, timeout counter 0..TIMEOUT-1.
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_TICKS - 1);
  // Timeout fires on the cycle where the incremented count reaches TIMEOUT-1,
  // so timeout_err lands exactly TIMEOUT cycles after the trig pulse.
  localparam logic [TW-1:0]    TO_FIRE  = TW'(TIMEOUT - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      trig          <= 1'b0;
      cam_id        <= 1'b0;
      row           <= '0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      frame_overrun <= 1'b0;
      sent_cnt      <= '0;
    end else begin
      // Single-cycle pulses default low.
      trig          <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      frame_overrun <= frame_start && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          row    <= '0;
          cam_id <= 1'b0;
          if (en && frame_start) begin
            state <= S_WAIT_LINE;
          end
        end

        S_WAIT_LINE: begin
          if (!en) begin
            state  <= S_IDLE;
            row    <= '0;
            cam_id <= 1'b0;
          end else if (line_ready && !tx_busy) begin
            // trig is registered, so it is high exactly while in ISSUE.
            state <= S_ISSUE;
            trig  <= 1'b1;
          end
        end

        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          to_cnt <= to_cnt + 1'b1;
          // tx_done takes priority over a coincident timeout.
          if (tx_done) begin
            sent_cnt <= sent_cnt + 16'd1;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end else if (to_cnt == TO_FIRE) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            // End of frame wins over an enable drop so frame_done is never lost.
            if (cam_id && (row == ROW_LAST)) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
              row        <= '0;
              cam_id     <= 1'b0;
            end else if (!en) begin
              state  <= S_IDLE;
              row    <= '0;
              cam_id <= 1'b0;
            end else begin
              state <= S_WAIT_LINE;
              if (!cam_id) begin
                cam_id <= 1'b1;
              end else begin
                cam_id <= 1'b0;
                row    <= row + 1'b1;
              end
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_line_scheduler.sv
module tb_udp_line_scheduler;

  localparam int V  = 4;
  localparam int RW = 3;
  localparam int GT = 3;
  localparam int TO = 20;
  localparam int NP = 2 * V;
  localparam int NV = 20;
  localparam int SL = 1024;

  logic          clk = 1'b0;
  logic          rst, en, frame_start, line_ready, tx_busy, tx_done;
  logic          trig, cam_id, frame_done, timeout_err, frame_overrun;
  logic [RW-1:0] row;
  logic [15:0]   sent_cnt;

  udp_line_scheduler #(
    .V_ACT(V), .ROW_W(RW), .GAP_TICKS(GT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .line_ready(line_ready), .tx_busy(tx_busy), .tx_done(tx_done),
    .trig(trig), .cam_id(cam_id), .row(row), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_overrun(frame_overrun), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, fs, rdy, busy, done;
    logic [23:0] exp;   // {trig, cam, row[2:0], frame_done, timeout_err, overrun, sent[15:0]}
  } vec_t;

  vec_t vecs[NV];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, base = 0, pend = -1;
  int obs_k, fd_cnt, ov_cnt;
  int exp_trig[NP], exp_wl[NP], delay[NP];
  int to_q[$];
  int fd_r, end_r, ov_r, drop_k, n_exp, sent_inc;
  int exp_sent = 0;
  bit busy_a[SL], nrdy_a[SL];
  bit mon_en = 1'b0, auto_done = 1'b0;

  function automatic vec_t mk(input logic r_i, e_i, f_i, rd_i, b_i, d_i,
                              input logic t, c, input int rw, input logic fd, to, ov,
                              input int s);
    vec_t v;
    v.rst = r_i; v.en = e_i; v.fs = f_i; v.rdy = rd_i; v.busy = b_i; v.done = d_i;
    v.exp = {t, c, 3'(rw), fd, to, ov, 16'(s)};
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, $signed(act), $signed(exp), cyc - base);
    end
  endtask

  // Frame-level expectations derived from the scheduling rules with plain arithmetic.
  task automatic model();
    int t, d, gs, ex;
    t = 1; n_exp = 0; sent_inc = 0; fd_r = -1; end_r = 0;
    to_q.delete();
    for (int k = 0; k < NP; k++) begin
      exp_wl[k] = t;
      while (t < SL && (busy_a[t] || nrdy_a[t])) t++;
      exp_trig[k] = t + 1;
      n_exp++;
      d = delay[k];
      if (d >= 1 && d <= TO - 1) begin
        sent_inc++;
        gs = exp_trig[k] + d + 1;
      end else begin
        to_q.push_back(exp_trig[k] + TO);
        gs = exp_trig[k] + TO;
      end
      ex = gs + GT - 1;
      end_r = ex + 1;
      if (k == NP - 1) begin
        fd_r = ex + 1;
        break;
      end
      if (k == drop_k) break;
      t = ex + 1;
    end
  endtask

  task automatic monitor();
    int r;
    r = cyc - base;
    if (obs_k < n_exp && r >= exp_wl[obs_k] && r < exp_trig[obs_k] && !trig) begin
      check("hold_row", 32'(row), obs_k / 2);
      check("hold_cam", 32'(cam_id), obs_k % 2);
    end
    if (trig) begin
      if (obs_k < n_exp) begin
        check("trig_cycle", r, exp_trig[obs_k]);
        check("trig_row", 32'(row), obs_k / 2);
        check("trig_cam", 32'(cam_id), obs_k % 2);
        pend = (delay[obs_k] > 0) ? cyc + delay[obs_k] : -1;
        obs_k++;
      end else begin
        check("extra_trig", 32'(trig), 0);
      end
    end
    if (timeout_err) begin
      check("timeout_cycle", r, (to_q.size() > 0) ? to_q[0] : -1);
      if (to_q.size() > 0) void'(to_q.pop_front());
    end
    if (frame_done) begin
      check("frame_done_cycle", r, fd_r);
      fd_cnt++;
    end
    if (frame_overrun) begin
      check("overrun_cycle", r, (ov_r >= 0) ? ov_r + 1 : -1);
      ov_cnt++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) monitor();
    if (auto_done) tx_done = (cyc == pend);
  endtask

  task automatic drive_stall(input int r);
    tx_busy    = (r < SL) ? busy_a[r] : 1'b0;
    line_ready = (r < SL) ? !nrdy_a[r] : 1'b1;
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < NP; k++) delay[k] = 5;
    for (int i = 0; i < SL; i++) begin
      busy_a[i] = 1'b0;
      nrdy_a[i] = 1'b0;
    end
    drop_k = -1;
  endtask

  // ov_mode: -1 none, 0 random, >0 fixed cycle offset for a stray frame_start.
  task automatic run_frame(input int ov_mode);
    int r;
    model();
    if (ov_mode > 0) ov_r = ov_mode;
    else if (ov_mode == 0 && $urandom_range(0, 1) == 1) ov_r = $urandom_range(1, exp_trig[n_exp-1]);
    else ov_r = -1;
    exp_sent += sent_inc;
    base = cyc; obs_k = 0; fd_cnt = 0; ov_cnt = 0; pend = -1;
    mon_en = 1'b1; auto_done = 1'b1;
    frame_start = 1'b1; en = 1'b1; drive_stall(0);
    while (cyc - base < end_r + 6) begin
      cycle();
      r = cyc - base;
      frame_start = (r == ov_r);
      en = !(drop_k >= 0 && r >= exp_trig[drop_k] + 1 && r < end_r);
      drive_stall(r);
    end
    mon_en = 1'b0; auto_done = 1'b0;
    tx_done = 1'b0; frame_start = 1'b0; en = 1'b1;
    tx_busy = 1'b0; line_ready = 1'b1;
    check("trig_count", obs_k, n_exp);
    check("timeouts_missing", to_q.size(), 0);
    check("frame_done_count", fd_cnt, (fd_r >= 0) ? 1 : 0);
    check("overrun_count", ov_cnt, (ov_r >= 0) ? 1 : 0);
    check("sent_cnt", 32'(sent_cnt), exp_sent & 32'hFFFF);
  endtask

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    logic [23:0] act;
    rst = 1'b1; en = 1'b0; frame_start = 1'b0; line_ready = 1'b1; tx_busy = 1'b0; tx_done = 1'b0;

    //              rst en fs rdy bsy done   trig cam row fd to ov sent
    vecs[0]  = mk(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1, 1);
    vecs[10] = mk(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vecs[11] = mk(0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    vecs[12] = mk(0, 1, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1);
    vecs[13] = mk(0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 1, 0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 2);
    vecs[15] = mk(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 2);
    vecs[16] = mk(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 2);
    vecs[17] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vecs[18] = mk(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vecs[19] = mk(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; frame_start = vecs[i].fs;
      line_ready = vecs[i].rdy; tx_busy = vecs[i].busy; tx_done = vecs[i].done;
      cycle();
      act = {trig, cam_id, row, frame_done, timeout_err, frame_overrun, sent_cnt};
      n_tests++;
      if (act !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec[%0d]: got %h, expected %h", i, act, vecs[i].exp);
      end
    end
    rst = 1'b0; en = 1'b1; frame_start = 1'b0; tx_done = 1'b0; line_ready = 1'b1; tx_busy = 1'b0;
    exp_sent = 2;
    repeat (2) cycle();

    // Nominal frame.
    clear_cfg();
    run_frame(-1);
    // Backpressure on the second packet (WAIT_LINE at offset 11).
    clear_cfg();
    for (int i = 11; i <= 25; i++) busy_a[i] = 1'b1;
    run_frame(-1);
    // Timeout on packet 3 plus a tx_done coinciding with the timeout point.
    clear_cfg();
    delay[2] = -1;
    delay[5] = TO - 1;
    run_frame(-1);
    // Enable drop during WAIT_DONE of (2,0).
    clear_cfg();
    drop_k = 4;
    run_frame(-1);
    // Stray frame_start mid-frame.
    clear_cfg();
    run_frame(15);

    // Synchronous reset in GAP; a later tx_done must be ignored.
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
    cycle();
    check("rst_seq_trig", 32'(trig), 1);
    repeat (3) cycle();
    tx_done = 1'b1; cycle(); tx_done = 1'b0;
    check("rst_seq_sent", 32'(sent_cnt), (exp_sent + 1) & 32'hFFFF);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_outputs", 32'({trig, cam_id, row, frame_done, timeout_err, frame_overrun, sent_cnt}), 0);
    tx_done = 1'b1; cycle(); tx_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("post_rst_idle", 32'({trig, timeout_err, sent_cnt}), 0);
    end
    exp_sent = 0;

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 20; n++) begin
      clear_cfg();
      for (int k = 0; k < NP; k++)
        delay[k] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 22));
      for (int i = 1; i < 400; i++) begin
        int x;
        x = $urandom_range(0, 7);
        busy_a[i] = (x == 0) || (x == 2);
        nrdy_a[i] = (x == 1) || (x == 2);
      end
      drop_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
      run_frame(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
